pingpong_frame_ctrl: RTL

- Ping-pong frame-buffer controller between the binary edge-image writer and the VGA scan-out.
- Owns two single-port-per-side frame RAMs (bank 0 and bank 1). One bank is written while the other is displayed.
- Swaps banks only at a display frame boundary, and only when a complete new frame is waiting.
- Provides a fixed 2-cycle read latency so that scan-out data aligns with a 2-stage display pipeline.

---
 rtl/pingpong_frame_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame-buffer controller: writer fills one bank while VGA scans out the other.
// Optional FRAME_DROP_CNT_EN adds a saturating count of frames dropped while a swap was pending.
module pingpong_frame_ctrl #(
  parameter int DATA_W     = 1,
  parameter int ADDR_W     = 16,
  parameter int FRAME_SIZE = 64000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_sof,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_din,
  input  logic              wr_end,
  output logic              wr_allow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic [DATA_W-1:0] dout,
  output logic              disp_valid,
`ifdef FRAME_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic              ram0_wr_en,
  output logic              ram1_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram0_rd_en,
  output logic              ram1_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram0_q,
  input  logic [DATA_W-1:0] ram1_q,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DROP} st_e;

  localparam logic [ADDR_W:0] FRAME_LIM = FRAME_SIZE[ADDR_W:0];

  st_e               state_q, state_d;
  logic              rd_sel_q, rd_sel_d;
  logic              disp_valid_q, disp_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              ram0_wr_en_q, ram0_wr_en_d;
  logic              ram1_wr_en_q, ram1_wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              swap, in_range, wr_ok;

  assign in_range = {1'b0, wr_addr} < FRAME_LIM;
  assign wr_ok    = (state_q == WRITE) && wr_en;
  // A frame completing in the same cycle as rd_end is swapped in immediately.
  assign swap     = rd_end && ((state_q == HOLD) || (state_q == DROP) ||
                               ((state_q == WRITE) && wr_end));

  always_comb begin
    state_d      = state_q;
    rd_sel_d     = rd_sel_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      IDLE:    if (wr_sof) state_d = WRITE;
      WRITE:   if (wr_end) state_d = HOLD;
               else if (wr_sof) state_d = WRITE;
      HOLD:    if (wr_sof) state_d = DROP;
      DROP:    if (wr_end) state_d = HOLD;
      default: state_d = IDLE;
    endcase
    if (swap) begin
      state_d      = IDLE;
      rd_sel_d     = ~rd_sel_q;
      disp_valid_d = 1'b1;
    end
  end

  always_comb begin
    ram0_wr_en_d = wr_ok && in_range && rd_sel_q;
    ram1_wr_en_d = wr_ok && in_range && !rd_sel_q;
    addr_err_d   = addr_err_q | (wr_ok && !in_range);
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (wr_ok && in_range) begin
      wr_addr_d = wr_addr;
      wr_data_d = wr_din;
    end
  end

  // Bank select travels with the read so the RAM's 1-cycle q lines up at dout.
  always_comb begin
    rd_vld_d  = rd_en;
    rd_bank_d = rd_sel_q;
    dout_d    = '0;
    if (rd_vld_q && disp_valid_q) dout_d = rd_bank_q ? ram1_q : ram0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_sel_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      ram0_wr_en_q <= 1'b0;
      ram1_wr_en_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_sel_q     <= rd_sel_d;
      disp_valid_q <= disp_valid_d;
      addr_err_q   <= addr_err_d;
      ram0_wr_en_q <= ram0_wr_en_d;
      ram1_wr_en_q <= ram1_wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_vld_q     <= rd_vld_d;
      rd_bank_q    <= rd_bank_d;
      dout_q       <= dout_d;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == HOLD) && (state_d == DROP) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign wr_allow    = (state_q == IDLE) || (state_q == WRITE);
  assign disp_valid  = disp_valid_q;
  assign addr_err    = addr_err_q;
  assign dout        = dout_q;
  assign ram0_wr_en  = ram0_wr_en_q;
  assign ram1_wr_en  = ram1_wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram0_rd_en  = rd_en && !rd_sel_q;
  assign ram1_rd_en  = rd_en && rd_sel_q;
  assign ram_rd_addr = rd_addr;

endmodule
